// File: rtl/reg_wb_sequencer_if.sv
// reg_wb_sequencer_if: writeback request handshakes and register file write ports.
// Build option WB_FWD_EN adds the forwarding lookup signals.
interface reg_wb_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                   alu_valid;
  logic                   alu_ready;
  logic [ADDR_W-1:0]      alu_dst;
  logic [DATA_W-1:0]      alu_data;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [ADDR_W-1:0]      mem_dst;
  logic [DATA_W-1:0]      mem_data;
  logic                   regWrite;
  logic [ADDR_W-1:0]      regDst1;
  logic [DATA_W-1:0]      bus_w;
  logic                   regWrite2;
  logic [ADDR_W-1:0]      regDst2;
  logic [DATA_W-1:0]      bus2_w;
  logic [(1<<ADDR_W)-1:0] pend_mask;
  logic                   idle;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0]      fwd_src;
  logic                   fwd_hit;
  logic [DATA_W-1:0]      fwd_data;

  modport master (
    output alu_valid, alu_dst, alu_data,
    output mem_valid, mem_dst, mem_data,
    output fwd_src,
    input  alu_ready, mem_ready,
    input  regWrite, regDst1, bus_w,
    input  regWrite2, regDst2, bus2_w,
    input  pend_mask, idle,
    input  fwd_hit, fwd_data
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  mem_valid, mem_dst, mem_data,
    input  fwd_src,
    output alu_ready, mem_ready,
    output regWrite, regDst1, bus_w,
    output regWrite2, regDst2, bus2_w,
    output pend_mask, idle,
    output fwd_hit, fwd_data
  );
`else
  modport master (
    output alu_valid, alu_dst, alu_data,
    output mem_valid, mem_dst, mem_data,
    input  alu_ready, mem_ready,
    input  regWrite, regDst1, bus_w,
    input  regWrite2, regDst2, bus2_w,
    input  pend_mask, idle
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  mem_valid, mem_dst, mem_data,
    output alu_ready, mem_ready,
    output regWrite, regDst1, bus_w,
    output regWrite2, regDst2, bus2_w,
    output pend_mask, idle
  );
`endif
endinterface

// File: rtl/reg_wb_sequencer.sv
// reg_wb_sequencer: ALU/load writeback FIFOs feeding both register file write ports.
// Build option WB_FWD_EN adds a combinational youngest-entry forwarding lookup.
module reg_wb_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               reset,
  reg_wb_sequencer_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SEQ_W = $clog2(2 * DEPTH) + 1;
  localparam int CNT_W = PTR_W + 2;
  localparam int NREG  = 1 << ADDR_W;

  logic [ADDR_W-1:0] r_a_dst [DEPTH];
  logic [DATA_W-1:0] r_a_dat [DEPTH];
  logic [SEQ_W-1:0]  r_a_seq [DEPTH];
  logic [ADDR_W-1:0] r_m_dst [DEPTH];
  logic [DATA_W-1:0] r_m_dat [DEPTH];
  logic [SEQ_W-1:0]  r_m_seq [DEPTH];
  logic [PTR_W:0]    r_a_wp, r_a_rp;
  logic [PTR_W:0]    r_m_wp, r_m_rp;
  logic [SEQ_W-1:0]  r_seq;
  logic [CNT_W-1:0]  r_pend [NREG];

  logic [PTR_W-1:0]  w_a_hd, w_m_hd;
  logic              w_a_empty, w_m_empty;
  logic              w_a_full, w_m_full;
  logic              w_a_push, w_m_push;
  logic              w_same, w_a_older;
  logic              w_wr1, w_wr2;
  logic [NREG-1:0]   w_pend;

  // Sign of the wrapped difference: a was tagged before b.
  function automatic logic older(
    input logic [SEQ_W-1:0] a,
    input logic [SEQ_W-1:0] b
  );
    logic [SEQ_W-1:0] d;
    d = a - b;
    return d[SEQ_W-1];
  endfunction

  assign w_a_hd    = r_a_rp[PTR_W-1:0];
  assign w_m_hd    = r_m_rp[PTR_W-1:0];
  assign w_a_empty = r_a_wp == r_a_rp;
  assign w_m_empty = r_m_wp == r_m_rp;
  assign w_a_full  = (r_a_wp[PTR_W] != r_a_rp[PTR_W]) &&
                     (r_a_wp[PTR_W-1:0] == r_a_rp[PTR_W-1:0]);
  assign w_m_full  = (r_m_wp[PTR_W] != r_m_rp[PTR_W]) &&
                     (r_m_wp[PTR_W-1:0] == r_m_rp[PTR_W-1:0]);

  assign wb.alu_ready = !reset && !w_a_full;
  assign wb.mem_ready = !reset && !w_m_full;
  assign w_a_push     = wb.alu_valid && wb.alu_ready;
  assign w_m_push     = wb.mem_valid && wb.mem_ready;

  // Same-register heads: only the older one may issue this cycle.
  assign w_same    = !w_a_empty && !w_m_empty &&
                     (r_a_dst[w_a_hd] == r_m_dst[w_m_hd]);
  assign w_a_older = older(r_a_seq[w_a_hd], r_m_seq[w_m_hd]);
  assign w_wr1     = !reset && !w_a_empty && !(w_same && !w_a_older);
  assign w_wr2     = !reset && !w_m_empty && !(w_same && w_a_older);

  assign wb.regWrite  = w_wr1;
  assign wb.regDst1   = w_wr1 ? r_a_dst[w_a_hd] : '0;
  assign wb.bus_w     = w_wr1 ? r_a_dat[w_a_hd] : '0;
  assign wb.regWrite2 = w_wr2;
  assign wb.regDst2   = w_wr2 ? r_m_dst[w_m_hd] : '0;
  assign wb.bus2_w    = w_wr2 ? r_m_dat[w_m_hd] : '0;
  assign wb.idle      = reset || (w_a_empty && w_m_empty);

  always_comb begin
    w_pend = '0;
    for (int r = 0; r < NREG; r++)
      w_pend[r] = !reset && (r_pend[r] != '0);
  end
  assign wb.pend_mask = w_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_wp <= '0;
      r_a_rp <= '0;
      r_m_wp <= '0;
      r_m_rp <= '0;
      r_seq  <= '0;
      for (int r = 0; r < NREG; r++)
        r_pend[r] <= '0;
    end else begin
      if (w_a_push) begin
        r_a_dst[r_a_wp[PTR_W-1:0]] <= wb.alu_dst;
        r_a_dat[r_a_wp[PTR_W-1:0]] <= wb.alu_data;
        r_a_seq[r_a_wp[PTR_W-1:0]] <= r_seq;
        r_a_wp <= r_a_wp + 1'b1;
      end
      if (w_m_push) begin
        r_m_dst[r_m_wp[PTR_W-1:0]] <= wb.mem_dst;
        r_m_dat[r_m_wp[PTR_W-1:0]] <= wb.mem_data;
        r_m_seq[r_m_wp[PTR_W-1:0]] <= r_seq + SEQ_W'(w_a_push);
        r_m_wp <= r_m_wp + 1'b1;
      end
      if (w_wr1)
        r_a_rp <= r_a_rp + 1'b1;
      if (w_wr2)
        r_m_rp <= r_m_rp + 1'b1;
      r_seq <= r_seq + SEQ_W'(w_a_push) + SEQ_W'(w_m_push);
      for (int r = 0; r < NREG; r++) begin
        r_pend[r] <= r_pend[r]
          + CNT_W'(w_a_push && (wb.alu_dst == ADDR_W'(r)))
          + CNT_W'(w_m_push && (wb.mem_dst == ADDR_W'(r)))
          - CNT_W'(w_wr1 && (r_a_dst[w_a_hd] == ADDR_W'(r)))
          - CNT_W'(w_wr2 && (r_m_dst[w_m_hd] == ADDR_W'(r)));
      end
    end
  end

`ifdef WB_FWD_EN
  logic              w_fhit;
  logic [DATA_W-1:0] w_fdat;
  logic [SEQ_W-1:0]  w_fseq;

  function automatic logic live(
    input logic [PTR_W-1:0] idx,
    input logic [PTR_W:0]   rp,
    input logic [PTR_W:0]   wp
  );
    logic [PTR_W-1:0] off;
    logic [PTR_W:0]   cnt;
    off = idx - rp[PTR_W-1:0];
    cnt = wp - rp;
    return {1'b0, off} < cnt;
  endfunction

  always_comb begin
    w_fhit = 1'b0;
    w_fdat = '0;
    w_fseq = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live(PTR_W'(i), r_a_rp, r_a_wp) &&
          (r_a_dst[i] == wb.fwd_src) &&
          (!w_fhit || older(w_fseq, r_a_seq[i]))) begin
        w_fhit = 1'b1;
        w_fdat = r_a_dat[i];
        w_fseq = r_a_seq[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (live(PTR_W'(i), r_m_rp, r_m_wp) &&
          (r_m_dst[i] == wb.fwd_src) &&
          (!w_fhit || older(w_fseq, r_m_seq[i]))) begin
        w_fhit = 1'b1;
        w_fdat = r_m_dat[i];
        w_fseq = r_m_seq[i];
      end
    end
  end

  assign wb.fwd_hit  = !reset && w_fhit;
  assign wb.fwd_data = reset ? '0 : w_fdat;
`endif
endmodule
